// File: rtl/traffic_display.sv
// Output stage for the auto-mode sequencer: registered lamp decode, flashing-yellow
// generator, sequential double-dabble BCD engine and a 4-digit multiplexed display.
module traffic_display #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] state,
  input  logic [6:0] timeLane1,
  input  logic [6:0] timeLane2,
  output logic [2:0] lamp1,
  output logic [2:0] lamp2,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       conv_busy
);

  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  localparam logic [2:0] ST_GR = 3'd3;
  localparam logic [2:0] ST_YR = 3'd4;
  localparam logic [2:0] ST_RG = 3'd5;
  localparam logic [2:0] ST_RY = 3'd6;

  typedef enum logic [1:0] {
    CONV_IDLE   = 2'd0,
    CONV_SHIFT  = 2'd1,
    CONV_COMMIT = 2'd2
  } conv_state_e;

  function automatic logic [6:0] clamp99(input logic [6:0] v);
    logic [6:0] r;
    if (v > 7'd99) r = 7'd99;
    else           r = v;
    return r;
  endfunction

  // Working word layout: [14:11] tens, [10:7] units, [6:0] binary still to shift in.
  function automatic logic [14:0] dd_step(input logic [14:0] w);
    logic [14:0] a;
    a = w;
    if (a[10:7] >= 4'd5)  a[10:7]  = a[10:7] + 4'd3;
    else                  a[10:7]  = a[10:7];
    if (a[14:11] >= 4'd5) a[14:11] = a[14:11] + 4'd3;
    else                  a[14:11] = a[14:11];
    return {a[13:0], 1'b0};
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [2:0]         lamp1_q, lamp1_d, lamp2_q, lamp2_d;
  logic [6:0]         seg_q, seg_d;
  logic [3:0]         an_q, an_d;
  logic               busy_q, busy_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  conv_state_e        conv_q, conv_d;
  logic [2:0]         shcnt_q, shcnt_d;
  logic [14:0]        work1_q, work1_d, work2_q, work2_d;
  logic [13:0]        snap_q, snap_d;
  logic [3:0]         d1t_q, d1t_d, d1u_q, d1u_d, d2t_q, d2t_d, d2u_q, d2u_d;
  logic [6:0]         c1_s, c2_s;
  logic [3:0]         dsel_s;

  assign c1_s = clamp99(timeLane1);
  assign c2_s = clamp99(timeLane2);

  always_comb begin
    lamp1_d = 3'b100;
    lamp2_d = 3'b100;
    if (!enable) begin
      lamp1_d = {1'b0, blink_ph_q, 1'b0};
      lamp2_d = {1'b0, blink_ph_q, 1'b0};
    end else begin
      case (state)
        ST_GR:   begin lamp1_d = 3'b001; lamp2_d = 3'b100; end
        ST_YR:   begin lamp1_d = 3'b010; lamp2_d = 3'b100; end
        ST_RG:   begin lamp1_d = 3'b100; lamp2_d = 3'b001; end
        ST_RY:   begin lamp1_d = 3'b100; lamp2_d = 3'b010; end
        default: begin lamp1_d = 3'b100; lamp2_d = 3'b100; end
      endcase
    end
  end

  // Blink generator is parked dark while enabled so flashing always starts with lamps off.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (enable) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end else begin
      idx_d      = idx_q;
    end
  end

  always_comb begin
    conv_d  = conv_q;
    shcnt_d = shcnt_q;
    work1_d = work1_q;
    work2_d = work2_q;
    snap_d  = snap_q;
    d1t_d   = d1t_q;
    d1u_d   = d1u_q;
    d2t_d   = d2t_q;
    d2u_d   = d2u_q;
    case (conv_q)
      CONV_IDLE: begin
        if ({c1_s, c2_s} != snap_q) begin
          work1_d = {8'd0, c1_s};
          work2_d = {8'd0, c2_s};
          snap_d  = {c1_s, c2_s};
          shcnt_d = 3'd0;
          conv_d  = CONV_SHIFT;
        end else begin
          conv_d  = CONV_IDLE;
        end
      end
      CONV_SHIFT: begin
        work1_d = dd_step(work1_q);
        work2_d = dd_step(work2_q);
        if (shcnt_q == 3'd6) begin
          conv_d  = CONV_COMMIT;
        end else begin
          shcnt_d = shcnt_q + 3'd1;
        end
      end
      CONV_COMMIT: begin
        d1t_d  = work1_q[14:11];
        d1u_d  = work1_q[10:7];
        d2t_d  = work2_q[14:11];
        d2u_d  = work2_q[10:7];
        conv_d = CONV_IDLE;
      end
      default: conv_d = CONV_IDLE;
    endcase
    busy_d = (conv_d != CONV_IDLE);
  end

  // Even indices are tens digits, which blank when zero.
  always_comb begin
    case (idx_q)
      2'd0:    dsel_s = d1t_q;
      2'd1:    dsel_s = d1u_q;
      2'd2:    dsel_s = d2t_q;
      2'd3:    dsel_s = d2u_q;
      default: dsel_s = 4'd0;
    endcase
    an_d  = 4'hF;
    seg_d = 7'h7F;
    if (!enable) begin
      an_d  = 4'hF;
      seg_d = 7'h7F;
    end else begin
      an_d = ~(4'b0001 << idx_q);
      if (!idx_q[0] && (dsel_s == 4'd0)) seg_d = 7'h7F;
      else                               seg_d = hex7(dsel_s);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lamp1_q     <= 3'b100;
      lamp2_q     <= 3'b100;
      seg_q       <= 7'h7F;
      an_q        <= 4'hF;
      busy_q      <= 1'b0;
      scan_cnt_q  <= '0;
      idx_q       <= 2'd0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      conv_q      <= CONV_IDLE;
      shcnt_q     <= 3'd0;
      work1_q     <= 15'd0;
      work2_q     <= 15'd0;
      snap_q      <= 14'd0;
      d1t_q       <= 4'd0;
      d1u_q       <= 4'd0;
      d2t_q       <= 4'd0;
      d2u_q       <= 4'd0;
    end else begin
      lamp1_q     <= lamp1_d;
      lamp2_q     <= lamp2_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      busy_q      <= busy_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      conv_q      <= conv_d;
      shcnt_q     <= shcnt_d;
      work1_q     <= work1_d;
      work2_q     <= work2_d;
      snap_q      <= snap_d;
      d1t_q       <= d1t_d;
      d1u_q       <= d1u_d;
      d2t_q       <= d2t_d;
      d2u_q       <= d2u_d;
    end
  end

  assign lamp1     = lamp1_q;
  assign lamp2     = lamp2_q;
  assign seg       = seg_q;
  assign an        = an_q;
  assign conv_busy = busy_q;

endmodule

// File: tb/tb_traffic_display.sv
// Directed bench for traffic_display with short scan/blink periods.
module tb_traffic_display;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [2:0] state;
  logic [6:0] tl1, tl2;
  logic [2:0] lamp1, lamp2;
  logic [6:0] seg;
  logic [3:0] an;
  logic       conv_busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] seg_tab [10];

  traffic_display #(.SCAN_DIV(4), .BLINK_DIV(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .state(state),
    .timeLane1(tl1), .timeLane2(tl2),
    .lamp1(lamp1), .lamp2(lamp2), .seg(seg), .an(an), .conv_busy(conv_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] st;
    logic [2:0] l1;
    logic [2:0] l2;
  } lamp_vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [3:0] a, input int t1, input int u1,
                                         input int t2, input int u2);
    case (a)
      4'hE:    return (t1 == 0) ? 7'h7F : seg_tab[t1];
      4'hD:    return seg_tab[u1];
      4'hB:    return (t2 == 0) ? 7'h7F : seg_tab[t2];
      4'h7:    return seg_tab[u2];
      default: return 7'h7F;
    endcase
  endfunction

  // Align to the start of the lane-1-tens slot, then walk all four digits in order.
  task automatic scan_check(input string name, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s [4];
    logic [3:0] exp_an;
    int k;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    k = 0;
    while (an == 4'hE && k < 20) begin tick(); k++; end
    while (an != 4'hE && k < 40) begin tick(); k++; end
    check({name, " sync"}, {28'd0, an}, 32'hE);
    for (int d = 0; d < 4; d++) begin
      exp_an = ~(4'b0001 << d);
      check($sformatf("%s an%0d", name, d), {28'd0, an}, {28'd0, exp_an});
      check($sformatf("%s seg%0d", name, d), {25'd0, seg}, {25'd0, s[d]});
      repeat (4) tick();
    end
  endtask

  initial begin
    lamp_vec_t vecs [6];
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    vecs[0] = '{1'b1, 3'd3, 3'b001, 3'b100};
    vecs[1] = '{1'b1, 3'd4, 3'b010, 3'b100};
    vecs[2] = '{1'b1, 3'd5, 3'b100, 3'b001};
    vecs[3] = '{1'b1, 3'd6, 3'b100, 3'b010};
    vecs[4] = '{1'b1, 3'd7, 3'b100, 3'b100};
    vecs[5] = '{1'b1, 3'd0, 3'b100, 3'b100};

    reset = 1'b0; enable = 1'b1; state = 3'd3; tl1 = 7'd0; tl2 = 7'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst lamp1 %0d", i), {29'd0, lamp1}, 32'h4);
      check($sformatf("rst lamp2 %0d", i), {29'd0, lamp2}, 32'h4);
      check($sformatf("rst an %0d", i), {28'd0, an}, 32'hF);
      check($sformatf("rst seg %0d", i), {25'd0, seg}, 32'h7F);
      check($sformatf("rst busy %0d", i), {31'd0, conv_busy}, 32'h0);
    end

    // 42 / 47: eight busy cycles, then the full scan.
    reset = 1'b1; tl1 = 7'd42; tl2 = 7'd47;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin
        check("gr lamp1", {29'd0, lamp1}, 32'h1);
        check("gr lamp2", {29'd0, lamp2}, 32'h4);
      end
      check($sformatf("busy42 %0d", i), {31'd0, conv_busy}, 32'h1);
    end
    tick();
    check("busy42 end", {31'd0, conv_busy}, 32'h0);
    tick();
    scan_check("d4247", 7'h19, 7'h24, 7'h19, 7'h78);

    foreach (vecs[i]) begin
      enable = vecs[i].en; state = vecs[i].st;
      tick();
      check($sformatf("sweep%0d lamp1", i), {29'd0, lamp1}, {29'd0, vecs[i].l1});
      check($sformatf("sweep%0d lamp2", i), {29'd0, lamp2}, {29'd0, vecs[i].l2});
    end

    // 7 / 120: blanked tens on lane 1, lane 2 clamps to 99.
    state = 3'd3; tl1 = 7'd7; tl2 = 7'd120;
    tick();
    check("busy7 start", {31'd0, conv_busy}, 32'h1);
    repeat (8) tick();
    check("busy7 end", {31'd0, conv_busy}, 32'h0);
    tick();
    scan_check("d7_99", 7'h7F, 7'h78, 7'h10, 7'h10);

    // 10 -> 9 in the middle of SHIFT: commit 10, then reconvert to 9.
    tl1 = 7'd10;
    tick();
    check("busy10 start", {31'd0, conv_busy}, 32'h1);
    repeat (2) tick();
    tl1 = 7'd9;
    repeat (6) tick();
    check("busy10 end", {31'd0, conv_busy}, 32'h0);
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 0) check("busy9 restart", {31'd0, conv_busy}, 32'h1);
      if (i == 8) check("busy9 end", {31'd0, conv_busy}, 32'h0);
      check($sformatf("stale10 seg %0d", i), {25'd0, seg}, {25'd0, exp_seg(an, 1, 0, 9, 9)});
    end
    tick();
    scan_check("d9_99", 7'h7F, 7'h10, 7'h10, 7'h10);

    // Flashing yellow while the engine converts 55 / 3 in the background.
    enable = 1'b0; tl1 = 7'd55; tl2 = 7'd3;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("blink lamp1 %0d", i), {29'd0, lamp1}, ((i / 3) % 2 == 1) ? 32'h2 : 32'h0);
      check($sformatf("blink lamp2 %0d", i), {29'd0, lamp2}, ((i / 3) % 2 == 1) ? 32'h2 : 32'h0);
      check($sformatf("blink an %0d", i), {28'd0, an}, 32'hF);
    end
    enable = 1'b1; state = 3'd5;
    tick();
    check("resume lamp1", {29'd0, lamp1}, 32'h4);
    check("resume lamp2", {29'd0, lamp2}, 32'h1);
    check("resume busy", {31'd0, conv_busy}, 32'h0);
    check("resume an lit", {31'd0, (an != 4'hF)}, 32'h1);
    check("resume seg", {25'd0, seg}, {25'd0, exp_seg(an, 5, 5, 0, 3)});
    scan_check("d55_3", 7'h12, 7'h12, 7'h7F, 7'h30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_display.md
Name: traffic_display

Overview:
- Output stage directly downstream of the auto-mode sequencer.
- Consumes the sequencer's state code and the two lane countdown values (timeLane1, timeLane2).
- Drives two 3-lamp signal heads and a 4-digit multiplexed 7-segment countdown display: digits 0-1 show lane 1, digits 2-3 show lane 2.
- Binary-to-BCD conversion is a sequential shift-add-3 (double-dabble) engine, re-run whenever either lane value changes.

Parameters:
- SCAN_DIV, 50000: clk cycles each digit stays lit; must be >= 2.
- BLINK_DIV, 25000000: clk cycles per half-period of the flashing-yellow pattern; must be >= 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- enable  input  1  auto mode active; same signal that drives the sequencer
- state  input  3  sequencer state code: GR=3, YR=4, RG=5, RY=6
- timeLane1  input  7  lane 1 remaining seconds, unsigned
- timeLane2  input  7  lane 2 remaining seconds, unsigned
- lamp1  output  3  lane 1 lamps {red,yellow,green}, active-high
- lamp2  output  3  lane 2 lamps {red,yellow,green}, active-high
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- an  output  4  digit enables, one-hot, active-low; an[0] = lane 1 tens
- conv_busy  output  1  high while the BCD engine is not in IDLE

Behaviour:
- Reset (reset==0 at posedge) sets all registers:
  - lamp1 = lamp2 = 3'b100; seg = 7'h7F; an = 4'hF; conv_busy = 0.
  - Scan prescaler = 0, digit index = 0, blink counter = 0, blink phase = 0.
  - BCD digit registers = 0; last-converted snapshot = {0,0}.
- Reset mid-conversion aborts the conversion; the partial result is discarded.
- Lamp decode is registered, with 1-cycle latency from state/enable:
  - enable=1, GR: lamp1=001, lamp2=100.
  - enable=1, YR: lamp1=010, lamp2=100.
  - enable=1, RG: lamp1=100, lamp2=001.
  - enable=1, RY: lamp1=100, lamp2=010.
  - enable=1, any other code: lamp1=lamp2=100 (fail-safe all-red).
  - enable=0: lamp1=lamp2={0,blink_phase,0}.
- Blink counter:
  - Counts 0..BLINK_DIV-1 and toggles blink_phase on wrap.
  - Free-runs only while enable=0.
  - Held at 0 with phase 0 while enable=1, so flashing always starts dark.
- Clamp: each lane value above 99 is converted as 99.
- BCD engine FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: if the clamped {timeLane1,timeLane2} differs from the snapshot, latch the clamped pair into the working shift registers and the snapshot, then go to SHIFT.
  - SHIFT: exactly 7 cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left by 1. Both lanes are processed in parallel.
  - COMMIT: 1 cycle. Write tens/units for both lanes into the digit registers, then return to IDLE.
  - conv_busy=1 in SHIFT and COMMIT.
  - Latency: a change sampled at edge N appears in the digit registers after edge N+8.
  - Input changes during SHIFT/COMMIT are ignored. They are caught by the next IDLE comparison, so there is no lost update.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1.
  - On wrap, the digit index increments mod 4, in the order 0,1,2,3,0.
- Digit output is registered from the index and digit registers, 1 cycle after the index changes:
  - an = ~(4'b0001 << index).
  - seg = active-low standard hex pattern of the selected BCD digit. Examples: 0=7'h40, 1=7'h79, 5=7'h12, 9=7'h10.
  - Leading-zero blank: a tens digit of 0 drives seg=7'h7F. A units digit is never blanked.
- enable=0:
  - an=4'hF and seg=7'h7F.
  - The scan and BCD engine keep running, so the display is correct immediately when enable rises.
- Simultaneous events:
  - Scan wrap during COMMIT: the output uses the digit registers as they were before that edge. The new digits show from the next cycle.
  - Reset has priority over everything.

Test Plan:
- Reset with reset=0 for 3 cycles, then release -> lamp1=lamp2=100, an=F, seg=7F, conv_busy=0 on every cycle of the reset hold.
- enable=1, state=3, timeLane1=42, timeLane2=47 -> conv_busy high for 8 cycles; digit regs become 4,2,4,7 after edge N+8. With SCAN_DIV=4, the scan shows an=E seg=19, an=D seg=24, an=B seg=19, an=7 seg=78. Lamps: lamp1=001, lamp2=100.
- Sweep state 3->4->5->6->7 with enable=1 -> the lamp pairs (001,100), (010,100), (100,001), (100,010), (100,100), each 1 cycle after the state change.
- timeLane1=7, timeLane2=120 -> an[0] digit seg=7F (blanked tens), lane 1 units seg=78, lane 2 shows 9,9 (seg=10,10).
- Change timeLane1 from 10 to 9 in the 3rd SHIFT cycle -> the first commit shows 1,0. A second conversion starts on the next IDLE and commits 9 with blank tens. No stale value persists beyond 17 cycles.
- enable=0 with BLINK_DIV=3 -> an=F, lamps toggle between 000 and 010 every 3 cycles starting at 000. Raising enable -> lamps follow the state after 1 cycle and the digits display immediately, with no new conversion required.
